// File: rtl/time_sync_pkg.sv
// Shared constants, state encodings and digit-limit helper for the time-sync receiver.
package time_sync_pkg;

  localparam logic [7:0] CH_HASH = 8'h23;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_ZERO = 8'h30;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} line_state_e;

  typedef enum logic [2:0] {P_IDLE, P_D0, P_D1, P_D2, P_D3, P_D4, P_D5, P_CR} parse_state_e;

  // Largest digit allowed at a position; the hour-ones limit depends on hour tens.
  function automatic logic [3:0] digit_max(input parse_state_e st, input logic [3:0] d0);
    case (st)
      P_D0:       return 4'd2;
      P_D1:       return (d0 == 4'd2) ? 4'd3 : 4'd9;
      P_D2, P_D4: return 4'd5;
      default:    return 4'd9;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: byte strobe one cycle after the stop-bit sample, ~2 cycles sync delay.
// No backpressure: each byte is offered for exactly one cycle.
module uart_rx_byte
  import time_sync_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       byte_ferr_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  line_state_e   state_q;
  logic          sync1_q, sync2_q, armed_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      armed_q      <= 1'b0;
      state_q      <= R_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_o       <= '0;
      byte_valid_o <= 1'b0;
      byte_ferr_o  <= 1'b0;
    end else begin
      sync1_q      <= rxd_i;
      sync2_q      <= sync1_q;
      byte_valid_o <= 1'b0;
      byte_ferr_o  <= 1'b0;
      case (state_q)
        R_IDLE: begin
          // armed_q only rises after the line has been seen high, so a held-low line cannot retrigger.
          armed_q <= sync2_q;
          cnt_q   <= '0;
          if (armed_q && !sync2_q) state_q <= R_START;
        end
        R_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= sync2_q ? R_IDLE : R_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        R_DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= R_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        R_STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q        <= '0;
            state_q      <= R_IDLE;
            armed_q      <= 1'b0;
            byte_o       <= shift_q;
            byte_valid_o <= sync2_q;
            byte_ferr_o  <= !sync2_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/time_sync_rx.sv
// Parses "#HHMMSS<CR>" into BCD time; load or frame_err one cycle after the deciding byte.
// No backpressure: partial frames wait indefinitely for the next byte.
module time_sync_rx
  import time_sync_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       load,
  output logic [1:0] hour_tens,
  output logic [3:0] hour_ones,
  output logic [2:0] min_tens,
  output logic [3:0] min_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       frame_err,
  output logic       busy
);

  logic [7:0]   rx_byte;
  logic         rx_vld, rx_ferr;
  parse_state_e p_q;
  logic [3:0]   sh_q [6];
  logic [7:0]   dval;
  logic         in_range;
  logic [2:0]   pos;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk          (clk),
    .rst          (rst),
    .rxd_i        (rxd),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_vld),
    .byte_ferr_o  (rx_ferr)
  );

  always_comb begin
    dval     = rx_byte - CH_ZERO;
    pos      = 3'(p_q) - 3'd1;
    in_range = (rx_byte >= CH_ZERO) && (rx_byte <= CH_ZERO + 8'd9) &&
               (dval[3:0] <= digit_max(p_q, sh_q[0]));
  end

  assign busy = (p_q != P_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q       <= P_IDLE;
      for (int i = 0; i < 6; i++) sh_q[i] <= '0;
      load      <= 1'b0;
      frame_err <= 1'b0;
      hour_tens <= '0;
      hour_ones <= '0;
      min_tens  <= '0;
      min_ones  <= '0;
      sec_tens  <= '0;
      sec_ones  <= '0;
    end else begin
      load      <= 1'b0;
      frame_err <= 1'b0;
      if (rx_ferr && p_q != P_IDLE) begin
        frame_err <= 1'b1;
        p_q       <= P_IDLE;
      end else if (rx_vld) begin
        case (p_q)
          P_IDLE: if (rx_byte == CH_HASH) p_q <= P_D0;
          P_CR: begin
            if (rx_byte == CH_CR) begin
              load      <= 1'b1;
              hour_tens <= sh_q[0][1:0];
              hour_ones <= sh_q[1];
              min_tens  <= sh_q[2][2:0];
              min_ones  <= sh_q[3];
              sec_tens  <= sh_q[4][2:0];
              sec_ones  <= sh_q[5];
              p_q       <= P_IDLE;
            end else begin
              frame_err <= 1'b1;
              p_q       <= (rx_byte == CH_HASH) ? P_D0 : P_IDLE;
            end
          end
          default: begin
            if (in_range) begin
              sh_q[pos] <= dval[3:0];
              p_q       <= parse_state_e'(3'(p_q) + 3'd1);
            end else begin
              // A stray '#' is taken as the start of a fresh frame.
              frame_err <= 1'b1;
              p_q       <= (rx_byte == CH_HASH) ? P_D0 : P_IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_time_sync_rx.sv
// Directed plus randomized frames against a string-level reference model of the time-sync protocol.
module tb_time_sync_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       load, frame_err, busy;
  logic [1:0] hour_tens;
  logic [3:0] hour_ones, min_ones, sec_ones;
  logic [2:0] min_tens, sec_tens;

  time_sync_rx #(.CLK_HZ(1_000_000), .BAUD(100_000)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .load      (load),
    .hour_tens (hour_tens),
    .hour_ones (hour_ones),
    .min_tens  (min_tens),
    .min_ones  (min_ones),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_load = 0, n_ferr = 0, n_busy = 0, n_both = 0, load_cyc = 0;
  always @(negedge clk) begin
    if (load) begin n_load++; load_cyc = cyc; end
    if (frame_err) n_ferr++;
    if (busy) n_busy++;
    if (load && frame_err) n_both++;
  end

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: number of frame characters collected so far ("#"=1) and the digits.
  int         mlen = 0;
  int         mdig [6];
  logic [19:0] exp_out = '0;

  function automatic bit prefix_ok(input int n);
    int d [6];
    for (int i = 0; i < 6; i++) d[i] = (i < n) ? mdig[i] : 0;
    return (d[0]*10 + d[1] <= 23) && (d[2]*10 + d[3] <= 59) && (d[4]*10 + d[5] <= 59);
  endfunction

  task automatic model_step(input logic [7:0] b, input logic stop, output int el, output int ef);
    el = 0; ef = 0;
    if (!stop) begin
      if (mlen != 0) begin ef = 1; mlen = 0; end
    end else if (mlen == 0) begin
      if (b == 8'h23) mlen = 1;
    end else if (mlen == 7) begin
      if (b == 8'h0D) begin
        el = 1; mlen = 0;
        exp_out = {2'(mdig[0]), 4'(mdig[1]), 3'(mdig[2]), 4'(mdig[3]), 3'(mdig[4]), 4'(mdig[5])};
      end else begin
        ef = 1; mlen = (b == 8'h23) ? 1 : 0;
      end
    end else begin
      bit ok = 0;
      if (b >= 8'h30 && b <= 8'h39) begin
        mdig[mlen-1] = int'(b) - 48;
        ok = prefix_ok(mlen);
      end
      if (ok) mlen++;
      else begin ef = 1; mlen = (b == 8'h23) ? 1 : 0; end
    end
  endtask

  function automatic logic [19:0] dut_out();
    return {hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop);
    int l0, f0, s, el, ef;
    model_step(b, stop, el, ef);
    l0 = n_load; f0 = n_ferr;
    @(negedge clk); rxd = 1'b0; s = cyc;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin rxd = b[i]; repeat (10) @(negedge clk); end
    rxd = stop; repeat (10) @(negedge clk);
    rxd = 1'b1; repeat (10) @(negedge clk);
    chk($sformatf("load_count byte %0h", b), n_load - l0, el);
    chk($sformatf("ferr_count byte %0h", b), n_ferr - f0, ef);
    // Edge seen 3 clocks after the start bit, stop sample 5+90 later, then byte strobe and load.
    if (el != 0) chk("load_latency", load_cyc - s, 99);
    chk("busy", busy, mlen != 0);
    chk("time_out", dut_out(), exp_out);
  endtask

  task automatic send_str(input string str);
    for (int i = 0; i < str.len(); i++) send_byte(str[i], 1'b1);
  endtask

  initial begin
    int l0, f0, bz0, kind, h, m, sc, bad;
    logic [7:0] fb [8];
    logic       st [8];

    repeat (3) @(negedge clk);
    chk("reset_outputs", {load, frame_err, busy, dut_out()}, 23'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    send_str("#123456\r");
    send_str("#245959\r");
    send_str("#12#235959\r");
    send_str("#000");
    send_byte(8'h30, 1'b0);
    send_str("#000000\r");
    send_str("#235959\r");
    send_str("#3");
    send_str("#12345#\r");

    // Short glitch must not start a byte.
    l0 = n_load; f0 = n_ferr; bz0 = n_busy;
    rxd = 1'b0; repeat (3) @(negedge clk);
    rxd = 1'b1; repeat (40) @(negedge clk);
    chk("glitch_strobes", (n_load - l0) + (n_ferr - f0), 0);
    chk("glitch_busy", n_busy - bz0, 0);

    // Reset in the middle of the D3 byte.
    send_str("#123456\r");
    send_str("#010");
    rxd = 1'b0; repeat (35) @(negedge clk);
    rst = 1'b1; rxd = 1'b1;
    repeat (2) @(negedge clk);
    chk("midframe_reset_outputs", {load, frame_err, busy, dut_out()}, 23'd0);
    rst = 1'b0;
    mlen = 0; exp_out = '0;
    repeat (20) @(negedge clk);
    send_str("#010203\r");

    for (int it = 0; it < 25; it++) begin
      kind = $urandom_range(0, 9);
      h = $urandom_range(0, 23); m = $urandom_range(0, 59); sc = $urandom_range(0, 59);
      fb[0] = 8'h23; fb[7] = 8'h0D;
      fb[1] = 8'(48 + h / 10);  fb[2] = 8'(48 + h % 10);
      fb[3] = 8'(48 + m / 10);  fb[4] = 8'(48 + m % 10);
      fb[5] = 8'(48 + sc / 10); fb[6] = 8'(48 + sc % 10);
      for (int i = 0; i < 8; i++) st[i] = 1'b1;
      if (kind == 6) for (int i = 1; i < 7; i++) fb[i] = 8'(48 + $urandom_range(0, 9));
      if (kind == 7) fb[$urandom_range(1, 7)] = 8'($urandom_range(0, 255));
      if (kind == 8) st[$urandom_range(0, 7)] = 1'b0;
      if (kind == 9) begin
        bad = $urandom_range(1, 6);
        fb[bad] = ($urandom_range(0, 1) == 0) ? 8'h23 : 8'(58 + $urandom_range(0, 5));
      end
      for (int i = 0; i < 8; i++) send_byte(fb[i], st[i]);
    end

    chk("load_ferr_overlap", n_both, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
